seizure_stim_controller: RTL and testbench
==========================================

# seizure_stim_controller

Sequencing controller placed between the feature datapath (line-length, non-linear energy and 4–70 Hz power outputs, each with its data-valid strobe and running baseline) and the stimulator output. It collects one window of the three features, which arrive at different cycles. It compares each feature against a scaled copy of its baseline and forms a weighted vote. After a programmable number of consecutive positive windows it drives a fixed-length stimulation pulse, followed by a refractory hold-off.

## Interface
- FEAT_WIDTH, 72, width of each feature and baseline input; ll_out is sign-extended to this width by the instantiating module.
- THR_SHIFT, 1, threshold scale; a feature exceeds when feature > (baseline << THR_SHIFT).
- W_LL, 2, vote weight of the line-length exceed bit (0–3).
- W_NE, 1, vote weight of the non-linear energy exceed bit (0–3).
- W_PS, 1, vote weight of the power exceed bit (0–3).
- VOTE_THR, 3, minimum weighted score for a window to be detected (1–9).
- N_CONSEC, 2, number of consecutive detected windows that triggers stimulation (≥1).
- STIM_LEN, 8, number of cycles stimulation is held high (≥1).
- REFRACT_LEN, 16, number of cycles after stimulation during which input is ignored (≥1).
- TIMEOUT, 32, maximum cycles from the first strobe of a window to its completion.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  active-low enable; when high, the block is held in COLLECT and cleared (synchronous).
- din_ll, din_ne, din_ps  in  FEAT_WIDTH each  signed feature values.
- base_ll, base_ne, base_ps  in  FEAT_WIDTH each  unsigned baselines, sampled together with their matching feature.
- valid_ll, valid_ne, valid_ps  in  1 each  single-cycle strobes qualifying the matching din/base pair.
- stimulation  out  1  registered stimulator drive.
- detect  out  1  one-cycle pulse for each window whose score ≥ VOTE_THR.
- exceed  out  3  registered {ps, ne, ll} exceed bits of the last evaluated window.
- consec_cnt  out  $clog2(N_CONSEC+1)  current run of consecutive detected windows.
- timeout_err  out  1  one-cycle pulse when a window is abandoned.
- state  out  2  encoding: COLLECT=0, EVAL=1, STIM=2, REFRACT=3.

## Operation
- Reset (rst=0) sets every output and internal register to 0, the state to COLLECT and the got[2:0] flags to 0.
- COLLECT:
  - On each valid_x, latch din_x and base_x and set got[x].
  - A repeated strobe for a feature that is already collected overwrites the held value with the newest.
  - When got, including any bits set in the current cycle, equals 3'b111, move to EVAL next cycle.
  - The timeout counter starts on the first got bit. If it reaches TIMEOUT while got≠111: clear got, clear consec_cnt, pulse timeout_err, stay in COLLECT.
- EVAL (exactly 1 cycle):
  - exceed_x = (din_x > 0) && (din_x > {base_x, THR_SHIFT zeros}); the comparison is made at FEAT_WIDTH+THR_SHIFT+1 bits, so no overflow is possible. A negative feature never exceeds.
  - score = W_LL·exceed_ll + W_NE·exceed_ne + W_PS·exceed_ps (4-bit).
  - If score ≥ VOTE_THR:
    - Pulse detect and increment consec_cnt.
    - If the new count equals N_CONSEC, go to STIM and clear consec_cnt; otherwise go to COLLECT.
  - Otherwise clear consec_cnt and go to COLLECT.
  - Clear got on leaving EVAL.
- STIM: stimulation=1 for exactly STIM_LEN cycles, then go to REFRACT.
- REFRACT: hold for REFRACT_LEN cycles, then go to COLLECT. All valid strobes in STIM and REFRACT are ignored, and got stays 0.
- en=1 in any state: next cycle the state is COLLECT, stimulation=0, got=0, consec_cnt=0 and the timeout counter is 0 (a running stimulation is aborted). detect and timeout_err are not asserted while en=1.

## Timing
- If the last strobe of a window is sampled at edge t, EVAL runs in cycle t+1.
- detect, exceed and consec_cnt update at edge t+2.
- On a trigger, state=STIM and stimulation rise at edge t+2 and stay high for cycles t+2 … t+STIM_LEN+1.
- REFRACT covers the following REFRACT_LEN cycles. The first strobe accepted after that is sampled at edge t+STIM_LEN+REFRACT_LEN+2.
- All three strobes arriving in the same cycle is a valid complete window.
- A strobe arriving in the EVAL cycle is dropped.
- Asynchronous reset asserted mid-stimulation drops stimulation immediately (not clock-qualified).

## Test plan
Defaults apply unless a scenario states otherwise.
- Reset and idle: hold rst=0, then release with no strobes → all outputs 0 and state=0 indefinitely, with no timeout_err.
- Staggered window, single detect: ll=500/base 100 at cycle 0, ne=10/base 100 at cycle 3, ps=300/base 100 at cycle 7 (score 3) → detect pulse at edge 9, exceed=3'b101, consec_cnt=1, stimulation stays 0.
- Trigger: two such windows back-to-back → stimulation high for exactly 8 cycles starting 2 edges after the second window completes, then 16 REFRACT cycles. Strobes sent during REFRACT produce no detect.
- Broken run: detect window, then a window with score 2 (only ne and ps exceed), then a detect window → consec_cnt goes 1, 0, 1, and no stimulation.
- Timeout: only valid_ll, then no strobes for 32 cycles → timeout_err pulse, got cleared, consec_cnt=0. A following full window evaluates normally.
- Abort and edge values: en=1 during cycle 3 of STIM → stimulation=0 and state=COLLECT the next cycle. Separately, din=-5 with base=0 → exceed bit 0; din=(base<<1)+1 → exceed bit 1; din=base<<1 → exceed bit 0.

Source files
------------

// File: rtl/seizure_stim_controller.sv
// ============================================================================
// seizure_stim_controller: three-feature weighted vote, consecutive-window
// trigger, fixed-length stimulation pulse and refractory hold-off.  Rev 1.0
// ============================================================================
`default_nettype none

module seizure_stim_controller #(
  parameter int FEAT_WIDTH  = 72,
  parameter int THR_SHIFT   = 1,
  parameter int W_LL        = 2,
  parameter int W_NE        = 1,
  parameter int W_PS        = 1,
  parameter int VOTE_THR    = 3,
  parameter int N_CONSEC    = 2,
  parameter int STIM_LEN    = 8,
  parameter int REFRACT_LEN = 16,
  parameter int TIMEOUT     = 32,
  localparam int CONSEC_W   = $clog2(N_CONSEC + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [FEAT_WIDTH-1:0] din_ll,
  input  logic signed [FEAT_WIDTH-1:0] din_ne,
  input  logic signed [FEAT_WIDTH-1:0] din_ps,
  input  logic        [FEAT_WIDTH-1:0] base_ll,
  input  logic        [FEAT_WIDTH-1:0] base_ne,
  input  logic        [FEAT_WIDTH-1:0] base_ps,
  input  logic                         valid_ll,
  input  logic                         valid_ne,
  input  logic                         valid_ps,
  output logic                         stimulation,
  output logic                         detect,
  output logic [2:0]                   exceed,
  output logic [CONSEC_W-1:0]          consec_cnt,
  output logic                         timeout_err,
  output logic [1:0]                   state
);

  localparam int CMP_W = FEAT_WIDTH + THR_SHIFT + 1;
  localparam int CNT_W = $clog2((STIM_LEN > REFRACT_LEN ? STIM_LEN : REFRACT_LEN) + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]    STIM_LAST = CNT_W'(STIM_LEN - 1);
  localparam logic [CNT_W-1:0]    REF_LAST  = CNT_W'(REFRACT_LEN - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CONSEC_W-1:0] CONSEC_N  = CONSEC_W'(N_CONSEC);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    STIM    = 2'd2,
    REFRACT = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [2:0]                   got_q, got_d;
  logic [2:0][FEAT_WIDTH-1:0]   din_q, din_d;
  logic [2:0][FEAT_WIDTH-1:0]   base_q, base_d;
  logic [TMO_W-1:0]             tmo_q, tmo_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CONSEC_W-1:0]          consec_q, consec_d;
  logic                         stim_q, stim_d;
  logic                         detect_q, detect_d;
  logic                         tout_q, tout_d;
  logic [2:0]                   exceed_q, exceed_d;

  logic [2:0]                   vld_w;
  logic [2:0][FEAT_WIDTH-1:0]   din_in_w, base_in_w;
  logic [2:0]                   exc_w;
  logic [3:0]                   score_w;
  logic                         hit_w;
  logic [CONSEC_W-1:0]          consec_inc_w;

  // Index 0 = line-length, 1 = non-linear energy, 2 = power.
  assign vld_w     = {valid_ps, valid_ne, valid_ll};
  assign din_in_w  = {din_ps, din_ne, din_ll};
  assign base_in_w = {base_ps, base_ne, base_ll};

  // Widened by THR_SHIFT+1 bits so the shifted baseline can never wrap.
  for (genvar i = 0; i < 3; i++) begin : g_exceed
    logic [CMP_W-1:0] feat_ext;
    logic [CMP_W-1:0] thr_ext;
    assign feat_ext = {{(THR_SHIFT + 1){din_q[i][FEAT_WIDTH-1]}}, din_q[i]};
    assign thr_ext  = {{(THR_SHIFT + 1){1'b0}}, base_q[i]} << THR_SHIFT;
    assign exc_w[i] = !feat_ext[CMP_W-1] && (feat_ext != '0) &&
                      ($signed(feat_ext) > $signed(thr_ext));
  end

  assign score_w = (exc_w[0] ? 4'(W_LL) : 4'd0) +
                   (exc_w[1] ? 4'(W_NE) : 4'd0) +
                   (exc_w[2] ? 4'(W_PS) : 4'd0);
  assign hit_w        = (score_w >= 4'(VOTE_THR));
  assign consec_inc_w = consec_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    got_d    = got_q;
    din_d    = din_q;
    base_d   = base_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    consec_d = consec_q;
    exceed_d = exceed_q;
    stim_d   = 1'b0;
    detect_d = 1'b0;
    tout_d   = 1'b0;

    if (en) begin
      state_d  = COLLECT;
      got_d    = 3'b000;
      tmo_d    = '0;
      cnt_d    = '0;
      consec_d = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          for (int i = 0; i < 3; i++) begin
            if (vld_w[i]) begin
              din_d[i]  = din_in_w[i];
              base_d[i] = base_in_w[i];
            end
          end
          got_d = got_q | vld_w;
          if (got_d == 3'b111) begin
            state_d = EVAL;
            tmo_d   = '0;
          end else if (got_d != 3'b000) begin
            // Window abandoned: the run of consecutive detections is broken too.
            if (tmo_q == TMO_LAST) begin
              got_d    = 3'b000;
              tmo_d    = '0;
              consec_d = '0;
              tout_d   = 1'b1;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
        end
        EVAL: begin
          got_d    = 3'b000;
          exceed_d = exc_w;
          state_d  = COLLECT;
          if (hit_w) begin
            detect_d = 1'b1;
            if (consec_inc_w == CONSEC_N) begin
              consec_d = '0;
              cnt_d    = '0;
              stim_d   = 1'b1;
              state_d  = STIM;
            end else begin
              consec_d = consec_inc_w;
            end
          end else begin
            consec_d = '0;
          end
        end
        STIM: begin
          if (cnt_q == STIM_LAST) begin
            cnt_d   = '0;
            state_d = REFRACT;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            stim_d = 1'b1;
          end
        end
        REFRACT: begin
          if (cnt_q == REF_LAST) begin
            cnt_d   = '0;
            state_d = COLLECT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= COLLECT;
      got_q    <= 3'b000;
      din_q    <= '0;
      base_q   <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      consec_q <= '0;
      exceed_q <= 3'b000;
      stim_q   <= 1'b0;
      detect_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      got_q    <= got_d;
      din_q    <= din_d;
      base_q   <= base_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      consec_q <= consec_d;
      exceed_q <= exceed_d;
      stim_q   <= stim_d;
      detect_q <= detect_d;
      tout_q   <= tout_d;
    end
  end

  assign stimulation = stim_q;
  assign detect      = detect_q;
  assign exceed      = exceed_q;
  assign consec_cnt  = consec_q;
  assign timeout_err = tout_q;
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_seizure_stim_controller.sv
// ============================================================================
// tb_seizure_stim_controller: directed self-checking bench for the stimulation
// sequencing controller (default parameters).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_seizure_stim_controller;

  logic        clk;
  logic        rst;
  logic        en;
  logic [71:0] din_ll, din_ne, din_ps;
  logic [71:0] base_ll, base_ne, base_ps;
  logic        valid_ll, valid_ne, valid_ps;
  logic        stimulation;
  logic        detect;
  logic [2:0]  exceed;
  logic [1:0]  consec_cnt;
  logic        timeout_err;
  logic [1:0]  state;

  int total;
  int bad;
  int n;

  seizure_stim_controller dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din_ll      (din_ll),
    .din_ne      (din_ne),
    .din_ps      (din_ps),
    .base_ll     (base_ll),
    .base_ne     (base_ne),
    .base_ps     (base_ps),
    .valid_ll    (valid_ll),
    .valid_ne    (valid_ne),
    .valid_ps    (valid_ps),
    .stimulation (stimulation),
    .detect      (detect),
    .exceed      (exceed),
    .consec_cnt  (consec_cnt),
    .timeout_err (timeout_err),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_valids();
    valid_ll = 1'b0;
    valid_ne = 1'b0;
    valid_ps = 1'b0;
  endtask

  // ll in cycle 0, ne in cycle 3, ps in cycle 7; returns just after the ps capture edge.
  task automatic send_window(input logic [71:0] dl, input logic [71:0] bl,
                             input logic [71:0] dn, input logic [71:0] bn,
                             input logic [71:0] dp, input logic [71:0] bp);
    din_ll = dl; base_ll = bl; valid_ll = 1'b1;
    step();
    clear_valids();
    step();
    step();
    din_ne = dn; base_ne = bn; valid_ne = 1'b1;
    step();
    clear_valids();
    step();
    step();
    step();
    din_ps = dp; base_ps = bp; valid_ps = 1'b1;
    step();
    clear_valids();
  endtask

  task automatic send_all(input logic [71:0] dl, input logic [71:0] bl,
                          input logic [71:0] dn, input logic [71:0] bn,
                          input logic [71:0] dp, input logic [71:0] bp);
    din_ll = dl; base_ll = bl;
    din_ne = dn; base_ne = bn;
    din_ps = dp; base_ps = bp;
    valid_ll = 1'b1; valid_ne = 1'b1; valid_ps = 1'b1;
    step();
    clear_valids();
  endtask

  task automatic det_window();
    send_window(72'd500, 72'd100, 72'd10, 72'd100, 72'd300, 72'd100);
  endtask

  task automatic en_pulse();
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    en    = 1'b0;
    din_ll = '0; din_ne = '0; din_ps = '0;
    base_ll = '0; base_ne = '0; base_ps = '0;
    clear_valids();

    // Reset and idle
    repeat (3) step();
    chk("rst_stim",   32'(stimulation), 0);
    chk("rst_detect", 32'(detect), 0);
    chk("rst_exceed", 32'(exceed), 0);
    chk("rst_consec", 32'(consec_cnt), 0);
    chk("rst_tout",   32'(timeout_err), 0);
    chk("rst_state",  32'(state), 0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("idle", 32'({timeout_err, stimulation, detect, consec_cnt, state}), 0);
    end

    // Staggered window, single detect
    det_window();
    chk("eval_state",  32'(state), 1);
    chk("eval_nodet",  32'(detect), 0);
    step();
    chk("det1_detect", 32'(detect), 1);
    chk("det1_exceed", 32'(exceed), 3'b101);
    chk("det1_consec", 32'(consec_cnt), 1);
    chk("det1_stim",   32'(stimulation), 0);
    chk("det1_state",  32'(state), 0);
    step();
    chk("det1_pulse",  32'(detect), 0);

    en_pulse();
    chk("en_clr_consec", 32'(consec_cnt), 0);
    chk("en_clr_state",  32'(state), 0);

    // Trigger: two detect windows back-to-back
    det_window();
    step();
    chk("trigA_detect", 32'(detect), 1);
    chk("trigA_consec", 32'(consec_cnt), 1);
    det_window();
    step();
    chk("trig_detect", 32'(detect), 1);
    chk("trig_consec", 32'(consec_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      chk("stim_hi",    32'(stimulation), 1);
      chk("stim_state", 32'(state), 2);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      chk("refr_state", 32'(state), 3);
      chk("refr_stim",  32'(stimulation), 0);
      chk("refr_nodet", 32'(detect), 0);
      if (i == 2) begin
        din_ll = 72'd500; base_ll = 72'd100;
        din_ne = 72'd500; base_ne = 72'd100;
        din_ps = 72'd500; base_ps = 72'd100;
        valid_ll = 1'b1; valid_ne = 1'b1; valid_ps = 1'b1;
      end else begin
        clear_valids();
      end
      step();
    end
    clear_valids();
    chk("post_refr_state", 32'(state), 0);
    chk("post_refr_nodet", 32'(detect), 0);
    send_all(72'd500, 72'd100, 72'd10, 72'd100, 72'd300, 72'd100);
    chk("first_acc_eval", 32'(state), 1);
    step();
    chk("first_acc_det",    32'(detect), 1);
    chk("first_acc_consec", 32'(consec_cnt), 1);

    // Broken run: detect, score 2, detect
    en_pulse();
    det_window();
    step();
    chk("brk1_consec", 32'(consec_cnt), 1);
    send_window(72'd50, 72'd100, 72'd500, 72'd100, 72'd500, 72'd100);
    step();
    chk("brk2_detect", 32'(detect), 0);
    chk("brk2_exceed", 32'(exceed), 3'b110);
    chk("brk2_consec", 32'(consec_cnt), 0);
    det_window();
    // Strobes in the EVAL cycle must be dropped
    din_ll = 72'd500; din_ne = 72'd500; din_ps = 72'd500;
    valid_ll = 1'b1; valid_ne = 1'b1; valid_ps = 1'b1;
    step();
    clear_valids();
    chk("brk3_detect", 32'(detect), 1);
    chk("brk3_consec", 32'(consec_cnt), 1);
    chk("brk3_stim",   32'(stimulation), 0);
    step();
    step();
    chk("eval_drop_state", 32'(state), 0);
    step();
    chk("eval_drop_det",   32'(detect), 0);

    // Timeout with only line-length collected
    din_ll = 72'd500; base_ll = 72'd100; valid_ll = 1'b1;
    step();
    clear_valids();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (timeout_err) break;
    end
    chk("tmo_cycles", 32'(n), 31);
    chk("tmo_pulse",  32'(timeout_err), 1);
    chk("tmo_consec", 32'(consec_cnt), 0);
    chk("tmo_state",  32'(state), 0);
    step();
    chk("tmo_one_cycle", 32'(timeout_err), 0);
    din_ne = 72'd500; base_ne = 72'd100; valid_ne = 1'b1;
    din_ps = 72'd500; base_ps = 72'd100; valid_ps = 1'b1;
    step();
    clear_valids();
    step();
    step();
    chk("tmo_got_clr_state", 32'(state), 0);
    chk("tmo_got_clr_det",   32'(detect), 0);
    din_ll = 72'd500; base_ll = 72'd100; valid_ll = 1'b1;
    step();
    clear_valids();
    chk("tmo_next_eval", 32'(state), 1);
    step();
    chk("tmo_next_det",    32'(detect), 1);
    chk("tmo_next_exceed", 32'(exceed), 3'b111);
    chk("tmo_next_consec", 32'(consec_cnt), 1);

    // Abort a running stimulation with en
    en_pulse();
    det_window();
    step();
    det_window();
    step();
    chk("abort_stim_on", 32'(stimulation), 1);
    step();
    step();
    chk("abort_stim_c3", 32'(stimulation), 1);
    en = 1'b1;
    step();
    chk("abort_stim",   32'(stimulation), 0);
    chk("abort_state",  32'(state), 0);
    chk("abort_consec", 32'(consec_cnt), 0);
    chk("abort_detect", 32'(detect), 0);
    en = 1'b0;

    // Threshold edge values, all three strobes in one cycle
    send_all(~72'd4, 72'd0, 72'd2001, 72'd1000, 72'd2000, 72'd1000);
    step();
    chk("edge_exceed", 32'(exceed), 3'b010);
    chk("edge_detect", 32'(detect), 0);
    send_all({1'b0, {71{1'b1}}}, {72{1'b1}},
             {1'b0, {71{1'b1}}}, {2'b00, {70{1'b1}}},
             {72{1'b1}}, 72'd0);
    step();
    chk("wide_exceed", 32'(exceed), 3'b010);

    // Asynchronous reset during stimulation
    det_window();
    step();
    det_window();
    step();
    step();
    chk("areset_pre", 32'(stimulation), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_stim",  32'(stimulation), 0);
    chk("areset_state", 32'(state), 0);
    step();
    rst = 1'b1;
    step();
    chk("areset_idle", 32'({stimulation, detect, state}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
